// File: rtl/seq_divider_16.sv
// seq_divider_16: sequential restoring divider, signed or unsigned.
// 16 shift-subtract cycles, one sign-fix cycle, then a done pulse.
module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [4:0]       cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] pquo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] diff;
    logic             q_neg;
    logic             r_neg;
    logic             dz_pend;
    logic             accept;
    logic             dz;

    // Operand magnitudes and the trial subtraction of one iteration
    always_comb begin
        a_mag  = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
        b_mag  = (signed_op && divisor[WIDTH-1]) ? -divisor : divisor;
        diff   = {prem, pquo[WIDTH-1]} - {2'b00, dvs};
        accept = (state == IDLE) && !dz_pend && start;
        dz     = (divisor == '0);
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (dz_pend)
                    state_nx = DONE;
                else if (start && !dz)
                    state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 5'd15)
                    state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            prem        <= '0;
            pquo        <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_pend     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            dz_pend <= accept && dz;
            if (accept) begin
                cnt         <= '0;
                prem        <= '0;
                pquo        <= a_mag;
                dvs         <= b_mag;
                q_neg       <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg       <= signed_op && dividend[WIDTH-1];
                div_by_zero <= dz;
                if (dz) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == RUN) begin
                prem <= diff[WIDTH+1] ? {prem[WIDTH-1:0], pquo[WIDTH-1]}
                                      : diff[WIDTH:0];
                pquo <= {pquo[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt  <= cnt + 5'd1;
            end else if (state == FIX) begin
                quotient  <= q_neg ? -pquo : pquo;
                remainder <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
            end
        end
    end

endmodule
